uart_rx_fifo: RTL and testbench

Synthesizable UART receiver with a receive FIFO and a valid/ready read port. It is the receive end of the serial link driven by the testbench UART checker's TX line: it deserialises frames in the same format the checker generates, which lets a bench loop the checker's `o_tx` into this block and read back the bytes. Its generics mirror the checker's so both ends are configured from the same constants.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states, parity modes and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } t_uart_state;

    localparam int C_PAR_NONE = 0;
    localparam int C_PAR_EVEN = 1;
    localparam int C_PAR_ODD  = 2;

    // Data is zero-extended to the widest frame; extra zeros do not alter the XOR.
    function automatic logic f_parity(input logic [8:0] data, input int mode);
        f_parity = (mode == C_PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read word
module sync_fifo #(
    parameter int G_WIDTH      = 8,
    parameter int G_ADDR_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [G_WIDTH-1:0] i_wdata,
    input  logic               i_pop,
    output logic [G_WIDTH-1:0] o_rdata,
    output logic               o_full,
    output logic               o_empty
);

    localparam int C_DEPTH = 2 ** G_ADDR_WIDTH;

    logic [G_WIDTH-1:0]    r_mem [C_DEPTH];
    logic [G_WIDTH-1:0]    r_rdata;
    logic [G_ADDR_WIDTH:0] r_wr_ptr;
    logic [G_ADDR_WIDTH:0] r_rd_ptr;
    logic [G_ADDR_WIDTH:0] w_wr_next;
    logic [G_ADDR_WIDTH:0] w_rd_next;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[G_ADDR_WIDTH] != r_rd_ptr[G_ADDR_WIDTH]) &&
                       (r_wr_ptr[G_ADDR_WIDTH-1:0] == r_rd_ptr[G_ADDR_WIDTH-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_wr_next = r_wr_ptr + {{G_ADDR_WIDTH{1'b0}}, w_do_push};
    assign w_rd_next = r_rd_ptr + {{G_ADDR_WIDTH{1'b0}}, w_do_pop};
    assign o_rdata   = r_rdata;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[G_ADDR_WIDTH-1:0]] <= i_wdata;
        end
    end

    // The head word is re-registered every cycle; bypass when the head slot is written now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rdata  <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            if (w_do_push && (r_wr_ptr[G_ADDR_WIDTH-1:0] == w_rd_next[G_ADDR_WIDTH-1:0])) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[w_rd_next[G_ADDR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a valid/ready receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int G_CLOCK_FREQ      = 20000000,
    parameter int G_BAUDRATE        = 1000000,
    parameter int G_DATA_WIDTH      = 8,
    parameter int G_PARITY          = 0,
    parameter int G_STOP_BIT_NUMBER = 1,
    parameter int G_FIRST_BIT       = 0,
    parameter int G_POLARITY        = 1,
    parameter int G_FIFO_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rx,
    output logic [G_DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_parity_err,
    output logic                    o_frame_err,
    output logic                    o_overflow,
    output logic                    o_busy
);

    localparam int C_DIV   = G_CLOCK_FREQ / G_BAUDRATE;
    localparam int C_CNT_W = $clog2(C_DIV);
    localparam int C_IDX_W = $clog2(G_DATA_WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_HALF = C_CNT_W'(C_DIV / 2);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(G_DATA_WIDTH - 1);
    localparam logic C_LAST_STOP = 1'(G_STOP_BIT_NUMBER - 1);

    t_uart_state             r_state;
    logic [1:0]              r_sync;
    logic                    r_prev;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_IDX_W-1:0]      r_bit_idx;
    logic                    r_stop_cnt;
    logic [G_DATA_WIDTH-1:0] r_shift;
    logic                    r_ferr_flag;
    logic                    r_perr_flag;
    logic                    r_eval;
    logic                    r_eval_ferr;
    logic                    r_eval_perr;
    logic [G_DATA_WIDTH-1:0] r_eval_word;
    logic                    r_parity_err;
    logic                    r_frame_err;
    logic                    r_overflow;
    logic                    w_rx;
    logic                    w_tick;
    logic [G_DATA_WIDTH-1:0] w_shift_next;
    logic                    w_push;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    assign w_rx   = r_sync[1] ^ (G_POLARITY == 0);
    assign w_tick = (r_cnt == C_CNT_LAST);
    assign w_push = r_eval && !r_eval_ferr && !r_eval_perr;

    always_comb begin
        w_shift_next = r_shift;
        if (G_FIRST_BIT == 0) begin
            w_shift_next = {w_rx, r_shift[G_DATA_WIDTH-1:1]};
        end else begin
            w_shift_next = {r_shift[G_DATA_WIDTH-2:0], w_rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= 2'b11;
            r_prev      <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_ferr_flag <= 1'b0;
            r_perr_flag <= 1'b0;
            r_eval      <= 1'b0;
            r_eval_ferr <= 1'b0;
            r_eval_perr <= 1'b0;
            r_eval_word <= '0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= w_rx;
            r_eval <= 1'b0;
            r_cnt  <= r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_prev && !w_rx) begin
                        r_state <= START;
                        r_cnt   <= C_CNT_HALF;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state     <= DATA;
                            r_bit_idx   <= '0;
                            r_ferr_flag <= 1'b0;
                            r_perr_flag <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_eval      <= 1'b1;
                            r_eval_ferr <= 1'b1;
                            r_eval_perr <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit_idx == C_LAST_IDX) begin
                            r_stop_cnt <= 1'b0;
                            r_state    <= (G_PARITY == C_PAR_NONE) ? STOP : PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_cnt       <= '0;
                        r_perr_flag <= (w_rx != f_parity(9'(r_shift), G_PARITY));
                        r_state     <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (r_stop_cnt == C_LAST_STOP) begin
                            r_state     <= IDLE;
                            r_eval      <= 1'b1;
                            r_eval_ferr <= r_ferr_flag | ~w_rx;
                            r_eval_perr <= r_perr_flag;
                            r_eval_word <= r_shift;
                        end else begin
                            r_stop_cnt  <= r_stop_cnt + 1'b1;
                            r_ferr_flag <= r_ferr_flag | ~w_rx;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO only overflows without one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_err  <= r_eval && r_eval_ferr;
            r_parity_err <= r_eval && !r_eval_ferr && r_eval_perr;
            if (w_push && w_fifo_full && !(o_valid && i_ready)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .G_WIDTH      (G_DATA_WIDTH),
        .G_ADDR_WIDTH (G_FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (r_eval_word),
        .i_pop   (i_ready),
        .o_rdata (o_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_valid      = ~w_fifo_empty;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int C_DIV = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_line;
    int   sel;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   stop_start;
    int   rise_cyc;
    int   valid_hi0;
    logic valid0_d = 1'b0;
    logic [7:0] cap_data0;
    int   perr_cnt [3];
    int   ferr_cnt [3];

    logic       rx0, rx1, rx2;
    logic       rdy0, rdy1, rdy2;
    logic [7:0] data0, data1, data2;
    logic       valid0, valid1, valid2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       ovf0, ovf1, ovf2;
    logic       busy0, busy1, busy2;

    assign rx0 = (sel == 0) ? tx_line : 1'b1;
    assign rx1 = (sel == 1) ? tx_line : 1'b1;
    assign rx2 = (sel == 2) ? ~tx_line : 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo dut0 (
        .clk(clk), .rst_n(rst_n), .i_rx(rx0), .o_data(data0), .o_valid(valid0),
        .i_ready(rdy0), .o_parity_err(perr0), .o_frame_err(ferr0),
        .o_overflow(ovf0), .o_busy(busy0)
    );

    uart_rx_fifo #(.G_PARITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_rx(rx1), .o_data(data1), .o_valid(valid1),
        .i_ready(rdy1), .o_parity_err(perr1), .o_frame_err(ferr1),
        .o_overflow(ovf1), .o_busy(busy1)
    );

    uart_rx_fifo #(.G_POLARITY(0), .G_FIRST_BIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_rx(rx2), .o_data(data2), .o_valid(valid2),
        .i_ready(rdy2), .o_parity_err(perr2), .o_frame_err(ferr2),
        .o_overflow(ovf2), .o_busy(busy2)
    );

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (perr0) perr_cnt[0]++;
        if (perr1) perr_cnt[1]++;
        if (perr2) perr_cnt[2]++;
        if (ferr0) ferr_cnt[0]++;
        if (ferr1) ferr_cnt[1]++;
        if (ferr2) ferr_cnt[2]++;
        if (valid0) begin
            valid_hi0++;
            if (!valid0_d) begin
                rise_cyc  = cyc;
                cap_data0 = data0;
            end
        end
        valid0_d = valid0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (C_DIV) @(posedge clk);
        #1;
    endtask

    // Serialises one 8-bit frame in the format selected DUT expects; par_force < 0 means correct parity.
    task automatic send_frame(input int s, input logic [7:0] d, input int par_force, input logic stop_v);
        sel = s;
        tx_line = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            tx_line = (s == 2) ? d[7-i] : d[i];
            wait_bit();
        end
        if (s == 1) begin
            tx_line = (par_force < 0) ? ^d : par_force[0];
            wait_bit();
        end
        stop_start = cyc;
        tx_line = stop_v;
        wait_bit();
        tx_line = 1'b1;
    endtask

    task automatic pop_check(input int s, input string tag, input logic [7:0] exp);
        case (s)
            0: begin check(tag, {valid0, data0}, {1'b1, exp}); rdy0 = 1'b1; end
            1: begin check(tag, {valid1, data1}, {1'b1, exp}); rdy1 = 1'b1; end
            default: begin check(tag, {valid2, data2}, {1'b1, exp}); rdy2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
    endtask

    logic [7:0] loop_bytes [4];

    initial begin
        loop_bytes = '{8'hFF, 8'h01, 8'hDD, 8'hCA};
        for (int i = 0; i < 3; i++) begin
            perr_cnt[i] = 0;
            ferr_cnt[i] = 0;
        end
        rst_n = 1'b0;
        tx_line = 1'b1;
        sel = 0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs0", {data0, valid0, perr0, ferr0, ovf0, busy0}, 13'h0);
        check("reset_outputs2", {data2, valid2, perr2, ferr2, ovf2, busy2}, 13'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_errors", ferr_cnt[0] + ferr_cnt[1] + ferr_cnt[2], 0);

        // Single byte, consumer always ready
        valid_hi0 = 0;
        rdy0 = 1'b1;
        send_frame(0, 8'hA5, -1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rdy0 = 1'b0;
        check("single_data", cap_data0, 8'hA5);
        check("single_latency", rise_cyc - stop_start, 14);
        check("single_valid_width", valid_hi0, 1);
        check("single_errs", perr_cnt[0] + ferr_cnt[0], 0);
        check("single_drained", valid0, 1'b0);

        // 17 back-to-back bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(0, 8'(i), -1, 1'b1);
        check("burst_overflow", ovf0, 1'b1);
        check("burst_errs", perr_cnt[0] + ferr_cnt[0], 0);
        for (int i = 0; i < 16; i++) pop_check(0, "burst_drain", 8'(i));
        check("burst_empty", valid0, 1'b0);

        // Even parity: 0x03 needs parity bit 0
        send_frame(1, 8'h03, 1, 1'b1);
        check("parity_bad_pulse", perr_cnt[1], 1);
        check("parity_bad_nopush", valid1, 1'b0);
        send_frame(1, 8'h03, 0, 1'b1);
        check("parity_good_nopulse", perr_cnt[1], 1);
        pop_check(1, "parity_good_data", 8'h03);
        check("parity_no_ferr", ferr_cnt[1], 0);

        // Bad stop bit, then a short glitch while idle
        send_frame(0, 8'h55, -1, 1'b0);
        check("stop_ferr_pulse", ferr_cnt[0], 1);
        check("stop_ferr_nopush", valid0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        tx_line = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_line = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_ferr_pulse", ferr_cnt[0], 2);
        check("glitch_idle", busy0, 1'b0);
        check("glitch_nopush", valid0, 1'b0);

        // Loopback sequence on the standard and the inverted MSB-first receivers
        for (int i = 0; i < 4; i++) send_frame(0, loop_bytes[i], -1, 1'b1);
        for (int i = 0; i < 4; i++) pop_check(0, "loop_std", loop_bytes[i]);
        check("loop_std_empty", valid0, 1'b0);
        for (int i = 0; i < 4; i++) send_frame(2, loop_bytes[i], -1, 1'b1);
        for (int i = 0; i < 4; i++) pop_check(2, "loop_inv", loop_bytes[i]);
        check("loop_inv_empty", valid2, 1'b0);
        check("loop_inv_errs", perr_cnt[2] + ferr_cnt[2], 0);

        // Reset during data bit 4 of 0x3C
        sel = 0;
        tx_line = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            tx_line = (8'h3C >> i) & 8'h01;
            wait_bit();
        end
        tx_line = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midframe_busy", busy0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midframe_reset_outputs", {data0, valid0, perr0, ferr0, ovf0, busy0}, 13'h0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        send_frame(0, 8'h81, -1, 1'b1);
        pop_check(0, "after_reset_data", 8'h81);
        check("after_reset_empty", valid0, 1'b0);
        check("after_reset_no_ovf", ovf0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
